// File: rtl/calc_port_arbiter_if.sv
// Request-port and shared-ALU signal bundle for calc_port_arbiter.
// slave is the arbiter side; master is the requesters/ALU side.
interface calc_port_arbiter_if;
  logic [15:0]  cmd_in;
  logic [127:0] data_in;
  logic [7:0]   tag_in;
  logic [7:0]   resp_out;
  logic [127:0] data_out;
  logic [7:0]   tag_out;
  logic         alu_valid;
  logic [3:0]   alu_cmd;
  logic [31:0]  alu_op1;
  logic [31:0]  alu_op2;
  logic         alu_done;
  logic [1:0]   alu_resp;
  logic [31:0]  alu_result;

  modport slave (
    input  cmd_in,
    input  data_in,
    input  tag_in,
    input  alu_done,
    input  alu_resp,
    input  alu_result,
    output resp_out,
    output data_out,
    output tag_out,
    output alu_valid,
    output alu_cmd,
    output alu_op1,
    output alu_op2
  );

  modport master (
    output cmd_in,
    output data_in,
    output tag_in,
    output alu_done,
    output alu_resp,
    output alu_result,
    input  resp_out,
    input  data_out,
    input  tag_out,
    input  alu_valid,
    input  alu_cmd,
    input  alu_op1,
    input  alu_op2
  );
endinterface

// File: rtl/calc_port_arbiter.sv
// Four-port request arbiter in front of one shared ALU.
// Round-robin grant, one op in flight, 15-cycle completion timeout.
module calc_port_arbiter (
  input  logic               clk,
  input  logic               reset,
  calc_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP2,
    S_PEND,
    S_BUSY
  } state_t;

  localparam int         NP       = 4;
  localparam logic [3:0] TMO_LAST = 4'd14;
  localparam logic [1:0] RSP_ERR  = 2'b10;

  state_t              r_state     [NP];
  state_t              w_state_nxt [NP];
  logic [3:0]          r_cmd [NP];
  logic [1:0]          r_tag [NP];
  logic [31:0]         r_op1 [NP];
  logic [31:0]         r_op2 [NP];

  logic [NP-1:0][1:0]  r_rsp;
  logic [NP-1:0][31:0] r_rdat;
  logic [NP-1:0][1:0]  r_rtag;
  logic [NP-1:0][1:0]  w_rsp;
  logic [NP-1:0][31:0] w_rdat;
  logic [NP-1:0]       w_rvld;
  logic [NP-1:0]       w_busy_vec;

  logic        r_busy;
  logic [1:0]  r_last;
  logic [3:0]  r_tmo;
  logic        r_alu_valid;
  logic [3:0]  r_alu_cmd;
  logic [31:0] r_alu_op1;
  logic [31:0] r_alu_op2;

  logic        w_done;
  logic        w_tmo;
  logic        w_free;
  logic        w_grant;
  logic [1:0]  w_gnt_idx;

  function automatic logic cmd_ok(input logic [3:0] c);
    return c inside {4'd1, 4'd2, 4'd5, 4'd6};
  endfunction

  // Completion only counts while an op is in flight.
  assign w_done = bus.alu_done && r_busy;
  assign w_tmo  = r_busy && !bus.alu_done
                  && (r_tmo == TMO_LAST);
  assign w_free = w_done || w_tmo;

  always_comb begin
    logic [1:0] cand;
    w_grant   = 1'b0;
    w_gnt_idx = r_last;
    cand      = r_last;
    for (int k = 1; k <= NP; k++) begin
      cand = r_last + 2'(k);
      if (!w_grant && !r_busy
          && r_state[cand] == S_PEND) begin
        w_grant   = 1'b1;
        w_gnt_idx = cand;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      w_state_nxt[p] = r_state[p];
      unique case (r_state[p])
        S_IDLE:
          if (bus.cmd_in[4*p +: 4] != 4'd0)
            w_state_nxt[p] = S_OP2;
        S_OP2:
          w_state_nxt[p] = cmd_ok(r_cmd[p])
                           ? S_PEND : S_IDLE;
        S_PEND:
          if (w_grant && w_gnt_idx == 2'(p))
            w_state_nxt[p] = S_BUSY;
        S_BUSY:
          if (w_free)
            w_state_nxt[p] = S_IDLE;
        default:
          w_state_nxt[p] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rvld     = '0;
    w_rsp      = '0;
    w_rdat     = '0;
    w_busy_vec = '0;
    for (int p = 0; p < NP; p++) begin
      w_busy_vec[p] = (r_state[p] == S_BUSY);
      unique case (1'b1)
        (r_state[p] == S_OP2) && !cmd_ok(r_cmd[p]): begin
          w_rvld[p] = 1'b1;
          w_rsp[p]  = RSP_ERR;
        end
        (r_state[p] == S_BUSY) && w_done: begin
          w_rvld[p] = 1'b1;
          w_rsp[p]  = bus.alu_resp;
          w_rdat[p] = bus.alu_result;
        end
        (r_state[p] == S_BUSY) && w_tmo: begin
          w_rvld[p] = 1'b1;
          w_rsp[p]  = RSP_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        r_state[p] <= S_IDLE;
        r_cmd[p]   <= '0;
        r_tag[p]   <= '0;
        r_op1[p]   <= '0;
        r_op2[p]   <= '0;
      end
      r_rsp       <= '0;
      r_rdat      <= '0;
      r_rtag      <= '0;
      r_busy      <= 1'b0;
      r_last      <= 2'd3;
      r_tmo       <= '0;
      r_alu_valid <= 1'b0;
      r_alu_cmd   <= '0;
      r_alu_op1   <= '0;
      r_alu_op2   <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        r_state[p] <= w_state_nxt[p];
        if (r_state[p] == S_IDLE
            && bus.cmd_in[4*p +: 4] != 4'd0) begin
          r_cmd[p] <= bus.cmd_in[4*p +: 4];
          r_tag[p] <= bus.tag_in[2*p +: 2];
          r_op1[p] <= bus.data_in[32*p +: 32];
        end
        if (r_state[p] == S_OP2)
          r_op2[p] <= bus.data_in[32*p +: 32];
        r_rsp[p]  <= w_rsp[p];
        r_rdat[p] <= w_rdat[p];
        r_rtag[p] <= w_rvld[p] ? r_tag[p] : 2'b00;
      end
      r_alu_valid <= w_grant;
      if (w_grant) begin
        r_alu_cmd <= r_cmd[w_gnt_idx];
        r_alu_op1 <= r_op1[w_gnt_idx];
        r_alu_op2 <= r_op2[w_gnt_idx];
        r_busy    <= 1'b1;
        r_last    <= w_gnt_idx;
        r_tmo     <= '0;
      end else if (w_free) begin
        r_busy <= 1'b0;
        r_tmo  <= '0;
      end else if (r_busy) begin
        r_tmo <= r_tmo + 4'd1;
      end
    end
  end

  assign bus.resp_out  = r_rsp;
  assign bus.data_out  = r_rdat;
  assign bus.tag_out   = r_rtag;
  assign bus.alu_valid = r_alu_valid;
  assign bus.alu_cmd   = r_alu_cmd;
  assign bus.alu_op1   = r_alu_op1;
  assign bus.alu_op2   = r_alu_op2;

  a_one_owner: assert property (
    @(posedge clk) disable iff (reset)
    $onehot0(w_busy_vec) && (r_busy == |w_busy_vec)
  );

  a_issue_pulse: assert property (
    @(posedge clk) disable iff (reset)
    r_alu_valid |=> !r_alu_valid
  );

endmodule

// File: tb/tb_calc_port_arbiter.sv
// Directed bench for calc_port_arbiter: per-cycle vector table
// followed by hand sequences for RR order, timeout, busy and reset.
module tb_calc_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  calc_port_arbiter_if bus ();

  calc_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic         rst;
    logic [15:0]  cmd;
    logic [127:0] din;
    logic [7:0]   tag;
    logic         done;
    logic [1:0]   aresp;
    logic [31:0]  ares;
    logic [7:0]   e_resp;
    logic [127:0] e_data;
    logic [7:0]   e_tag;
    logic         e_vld;
    logic [3:0]   e_cmd;
    logic [31:0]  e_op1;
    logic [31:0]  e_op2;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.cmd_in     = '0;
    bus.data_in    = '0;
    bus.tag_in     = '0;
    bus.alu_done   = 1'b0;
    bus.alu_resp   = '0;
    bus.alu_result = '0;
  endtask

  function automatic vec_t hold(input vec_t v);
    vec_t r;
    r       = v;
    r.e_cmd = 4'd1;
    r.e_op1 = 32'd5;
    r.e_op2 = 32'd7;
    return r;
  endfunction

  task automatic add_row(input vec_t v);
    tv.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   w;
    int   late;
    logic [7:0]   er;
    logic [7:0]   et;
    logic [127:0] ed;

    // reset rows
    v = '0; v.rst = 1'b1; add_row(v);
    v = '0; v.rst = 1'b1; add_row(v);
    // port 0 add 5+7, tag 2, ALU answers two cycles after issue
    v = '0; v.cmd[3:0] = 4'd1; v.din[31:0] = 32'd5;
    v.tag[1:0] = 2'd2; add_row(v);
    v = '0; v.din[31:0] = 32'd7; add_row(v);
    v = hold('0); v.e_vld = 1'b1; add_row(v);
    v = hold('0); add_row(v);
    v = hold('0); add_row(v);
    v = hold('0); v.done = 1'b1; v.aresp = 2'b01; v.ares = 32'd12;
    v.e_resp = 8'h01; v.e_data = 128'd12; v.e_tag = 8'h02;
    add_row(v);
    v = hold('0); add_row(v);
    // port 3 invalid cmd 4
    v = hold('0); v.cmd[15:12] = 4'd4; v.din[127:96] = 32'h55;
    v.tag[7:6] = 2'd1; add_row(v);
    v = hold('0); v.din[127:96] = 32'h66;
    v.e_resp = 8'h80; v.e_tag = 8'h40; add_row(v);
    v = hold('0); add_row(v);
    v = hold('0); add_row(v);
    // ports 1 and 2 invalid cmds 15 and 3 together
    v = hold('0); v.cmd = 16'h03F0; v.tag = 8'h2C; add_row(v);
    v = hold('0); v.e_resp = 8'h28; v.e_tag = 8'h2C; add_row(v);
    v = hold('0); add_row(v);
    // spurious done with nothing outstanding
    v = hold('0); v.done = 1'b1; v.aresp = 2'b01; v.ares = 32'd99;
    add_row(v);
    v = hold('0); add_row(v);
    v = hold('0); add_row(v);

    for (int i = 0; i < tv.size(); i++) begin
      reset          = tv[i].rst;
      bus.cmd_in     = tv[i].cmd;
      bus.data_in    = tv[i].din;
      bus.tag_in     = tv[i].tag;
      bus.alu_done   = tv[i].done;
      bus.alu_resp   = tv[i].aresp;
      bus.alu_result = tv[i].ares;
      tick();
      chk($sformatf("v%0d resp", i), bus.resp_out, tv[i].e_resp);
      chk($sformatf("v%0d data", i), bus.data_out, tv[i].e_data);
      chk($sformatf("v%0d tag", i), bus.tag_out, tv[i].e_tag);
      chk($sformatf("v%0d vld", i), bus.alu_valid, tv[i].e_vld);
      chk($sformatf("v%0d cmd", i), bus.alu_cmd, tv[i].e_cmd);
      chk($sformatf("v%0d op1", i), bus.alu_op1, tv[i].e_op1);
      chk($sformatf("v%0d op2", i), bus.alu_op2, tv[i].e_op2);
    end
    reset = 1'b0;
    idle_in();

    // all four ports at once, after reset -> order 0,1,2,3
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("A rst cmd", bus.alu_cmd, 4'd0);
    chk("A rst op1", bus.alu_op1, 32'd0);
    bus.cmd_in  = 16'h1111;
    bus.tag_in  = 8'hE4;
    bus.data_in = {32'd13, 32'd12, 32'd11, 32'd10};
    tick();
    bus.cmd_in  = '0;
    bus.tag_in  = '0;
    bus.data_in = {32'd23, 32'd22, 32'd21, 32'd20};
    tick();
    bus.data_in = '0;
    tick();
    for (int p = 0; p < 4; p++) begin
      w = 0;
      while (!bus.alu_valid && w < 20) begin
        tick();
        w++;
      end
      chk($sformatf("A%0d wait", p), w, (p == 0) ? 0 : 1);
      chk($sformatf("A%0d cmd", p), bus.alu_cmd, 4'd1);
      chk($sformatf("A%0d op1", p), bus.alu_op1, 10 + p);
      chk($sformatf("A%0d op2", p), bus.alu_op2, 20 + p);
      tick();
      chk($sformatf("A%0d pulse", p), bus.alu_valid, 1'b0);
      bus.alu_done   = 1'b1;
      bus.alu_resp   = 2'b01;
      bus.alu_result = 32'(100 + p);
      tick();
      bus.alu_done = 1'b0;
      er = 8'h01 << (2 * p);
      et = 8'(p) << (2 * p);
      ed = 128'(100 + p) << (32 * p);
      chk($sformatf("A%0d resp", p), bus.resp_out, er);
      chk($sformatf("A%0d tag", p), bus.tag_out, et);
      chk($sformatf("A%0d data", p), bus.data_out, ed);
      chk($sformatf("A%0d vld", p), bus.alu_valid, 1'b0);
    end
    tick();

    // port 2 times out, port 1 waits in PEND behind it
    bus.cmd_in  = 16'h0200;
    bus.tag_in  = 8'h30;
    bus.data_in = 128'(32'h40) << 64;
    tick();
    bus.cmd_in  = 16'h0050;
    bus.tag_in  = 8'h04;
    bus.data_in = (128'(32'h2) << 64) | (128'(32'h41) << 32);
    tick();
    bus.cmd_in  = '0;
    bus.tag_in  = '0;
    bus.data_in = 128'(32'h3) << 32;
    tick();
    bus.data_in = '0;
    chk("B vld", bus.alu_valid, 1'b1);
    chk("B cmd", bus.alu_cmd, 4'd2);
    chk("B op1", bus.alu_op1, 32'h40);
    chk("B op2", bus.alu_op2, 32'h2);
    late = 0;
    for (int t = 1; t < 15; t++) begin
      tick();
      if (bus.resp_out != 0 || bus.alu_valid) late++;
    end
    chk("B early", late, 0);
    tick();
    chk("B to resp", bus.resp_out, 8'h20);
    chk("B to tag", bus.tag_out, 8'h30);
    chk("B to data", bus.data_out, 128'd0);
    tick();
    chk("B next vld", bus.alu_valid, 1'b1);
    chk("B next cmd", bus.alu_cmd, 4'd5);
    chk("B next op1", bus.alu_op1, 32'h41);
    chk("B next op2", bus.alu_op2, 32'h3);
    chk("B no resp", bus.resp_out, 8'h00);
    bus.alu_done   = 1'b1;
    bus.alu_resp   = 2'b11;
    bus.alu_result = 32'hABCD;
    tick();
    bus.alu_done = 1'b0;
    chk("B p1 resp", bus.resp_out, 8'h0C);
    chk("B p1 tag", bus.tag_out, 8'h04);
    chk("B p1 data", bus.data_out, 128'(32'hABCD) << 32);
    tick();

    // port 1 new cmd while BUSY is ignored
    bus.cmd_in  = 16'h0060;
    bus.tag_in  = 8'h04;
    bus.data_in = 128'(32'h80) << 32;
    tick();
    bus.cmd_in  = '0;
    bus.tag_in  = '0;
    bus.data_in = 128'(32'h3) << 32;
    tick();
    bus.data_in = '0;
    tick();
    chk("C vld", bus.alu_valid, 1'b1);
    chk("C cmd", bus.alu_cmd, 4'd6);
    bus.cmd_in  = 16'h0010;
    bus.tag_in  = 8'h0C;
    bus.data_in = 128'(32'hDEAD) << 32;
    tick();
    bus.cmd_in  = '0;
    bus.tag_in  = '0;
    bus.data_in = '0;
    tick();
    bus.alu_done   = 1'b1;
    bus.alu_resp   = 2'b01;
    bus.alu_result = 32'h10;
    tick();
    bus.alu_done = 1'b0;
    chk("C resp", bus.resp_out, 8'h04);
    chk("C tag", bus.tag_out, 8'h04);
    chk("C data", bus.data_out, 128'(32'h10) << 32);
    late = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (bus.resp_out != 0 || bus.alu_valid) late++;
    end
    chk("C extra", late, 0);
    chk("C op1 hold", bus.alu_op1, 32'h80);

    // reset while port 0 is BUSY, then a late done
    bus.cmd_in  = 16'h0001;
    bus.tag_in  = 8'h01;
    bus.data_in = 128'(32'h9);
    tick();
    bus.cmd_in  = '0;
    bus.tag_in  = '0;
    bus.data_in = 128'(32'h4);
    tick();
    bus.data_in = '0;
    tick();
    chk("D vld", bus.alu_valid, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("D rst vld", bus.alu_valid, 1'b0);
    chk("D rst cmd", bus.alu_cmd, 4'd0);
    chk("D rst op1", bus.alu_op1, 32'd0);
    chk("D rst op2", bus.alu_op2, 32'd0);
    chk("D rst resp", bus.resp_out, 8'h00);
    chk("D rst data", bus.data_out, 128'd0);
    chk("D rst tag", bus.tag_out, 8'h00);
    bus.alu_done   = 1'b1;
    bus.alu_resp   = 2'b01;
    bus.alu_result = 32'h77;
    tick();
    bus.alu_done = 1'b0;
    late = 0;
    for (int t = 0; t < 4; t++) begin
      if (bus.resp_out != 0 || bus.data_out != 0
          || bus.tag_out != 0 || bus.alu_valid) late++;
      tick();
    end
    chk("D late done", late, 0);

    // pointer restarts at port 0 after reset
    bus.cmd_in  = 16'h1001;
    bus.data_in = {32'h33, 64'h0, 32'h30};
    tick();
    bus.cmd_in  = '0;
    bus.data_in = {32'h34, 64'h0, 32'h31};
    tick();
    bus.data_in = '0;
    tick();
    chk("D rr0 vld", bus.alu_valid, 1'b1);
    chk("D rr0 op1", bus.alu_op1, 32'h30);
    bus.alu_done   = 1'b1;
    bus.alu_resp   = 2'b01;
    bus.alu_result = 32'h1;
    tick();
    bus.alu_done = 1'b0;
    chk("D rr0 resp", bus.resp_out, 8'h01);
    tick();
    chk("D rr3 vld", bus.alu_valid, 1'b1);
    chk("D rr3 op1", bus.alu_op1, 32'h33);
    chk("D rr3 op2", bus.alu_op2, 32'h34);
    bus.alu_done   = 1'b1;
    bus.alu_resp   = 2'b01;
    bus.alu_result = 32'h2;
    tick();
    bus.alu_done = 1'b0;
    chk("D rr3 resp", bus.resp_out, 8'h40);
    chk("D rr3 data", bus.data_out, 128'(32'h2) << 96);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
